// File: rtl/mem_pkg.sv
// mem_pkg: shared constants, lane helper and response tag for the data memory
package mem_pkg;
  localparam int MAX_READ_LATENCY = 4;
  function automatic int lanes(input int data_width);
    return data_width / 8;
  endfunction
  typedef struct packed {
    logic valid;
    logic error;
  } resp_tag_t;
endpackage

// File: rtl/mem_read_pipe.sv
// mem_read_pipe: READ_LATENCY-deep response shift register with hold-on-enable
module mem_read_pipe
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  resp_tag_t             in_tag,
  input  logic [DATA_WIDTH-1:0] in_data,
  output resp_tag_t             out_tag,
  output logic [DATA_WIDTH-1:0] out_data
);
  resp_tag_t             tag_q  [READ_LATENCY];
  logic [DATA_WIDTH-1:0] data_q [READ_LATENCY];
  // Shift tags every enabled cycle; data only moves with a valid tag so bubbles leave it held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (enable) begin
      tag_q[0]  <= in_tag;
      data_q[0] <= in_tag.valid ? in_data : data_q[0];
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_q[i]  <= tag_q[i-1];
        data_q[i] <= tag_q[i-1].valid ? data_q[i-1] : data_q[i];
      end
    end
  end
  assign out_tag  = tag_q[READ_LATENCY-1];
  assign out_data = data_q[READ_LATENCY-1];
endmodule

// File: rtl/pipelined_data_mem.sv
// pipelined_data_mem: byte-maskable word RAM with write-first reads and a tagged read pipeline
module pipelined_data_mem
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int DEPTH        = 256,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_enable,
  input  logic                    r_enable,
  input  logic [ADDR_WIDTH-1:0]   r_address,
  input  logic                    w_enable,
  input  logic [ADDR_WIDTH-1:0]   w_address,
  input  logic [DATA_WIDTH-1:0]   w_data,
  input  logic [DATA_WIDTH/8-1:0] w_byte_enable,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic                    o_valid,
  output logic                    o_error
);
  localparam int LANES = lanes(DATA_WIDTH);
  if (DATA_WIDTH % 8 != 0 || DEPTH < 1 || DEPTH > 2**ADDR_WIDTH ||
      READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_params
    $error("pipelined_data_mem: illegal parameter combination");
  end
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  w_ok, r_ok, hit;
  logic [DATA_WIDTH-1:0] rd_data;
  resp_tag_t             in_tag, out_tag;
  assign w_ok = 32'(w_address) < DEPTH;
  assign r_ok = 32'(r_address) < DEPTH;
  assign hit  = w_enable && w_ok && w_address == r_address;
  // Byte-masked write; out-of-range addresses are dropped
  always_ff @(posedge clk) begin
    if (clk_enable && w_enable && w_ok)
      for (int b = 0; b < LANES; b++)
        if (w_byte_enable[b]) mem[w_address][8*b +: 8] <= w_data[8*b +: 8];
  end
  // Sample the array, zero it out of range, and forward same-address write bytes
  always_comb begin
    rd_data = r_ok ? mem[r_address] : '0;
    for (int b = 0; b < LANES; b++)
      if (hit && w_byte_enable[b]) rd_data[8*b +: 8] = w_data[8*b +: 8];
  end
  assign in_tag = '{valid: r_enable, error: r_enable && !r_ok};
  mem_read_pipe #(.DATA_WIDTH(DATA_WIDTH), .READ_LATENCY(READ_LATENCY)) u_pipe (
    .clk(clk), .rst(rst), .enable(clk_enable),
    .in_tag(in_tag), .in_data(rd_data),
    .out_tag(out_tag), .out_data(o_data)
  );
  assign o_valid = out_tag.valid;
  assign o_error = out_tag.error;
endmodule

// File: tb/tb_pipelined_data_mem.sv
// tb_pipelined_data_mem: randomized scoreboard bench against a word-array reference model
module tb_pipelined_data_mem;
  localparam int DEPTH = 200;
  localparam int RL    = 3;
  logic        clk = 0;
  logic        rst = 1;
  logic        clk_enable = 0, r_enable = 0, w_enable = 0;
  logic [7:0]  r_address = 0, w_address = 0;
  logic [31:0] w_data = 0;
  logic [3:0]  w_byte_enable = 0;
  logic [31:0] o_data;
  logic        o_valid, o_error;

  pipelined_data_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(DEPTH), .READ_LATENCY(RL)) dut (
    .clk(clk), .rst(rst), .clk_enable(clk_enable),
    .r_enable(r_enable), .r_address(r_address),
    .w_enable(w_enable), .w_address(w_address), .w_data(w_data), .w_byte_enable(w_byte_enable),
    .o_data(o_data), .o_valid(o_valid), .o_error(o_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] data;
  } exp_t;
  exp_t        q[$];
  logic [31:0] ref_mem [256];
  int          ecyc = 0, last = 0;
  int          checks = 0, errors = 0;
  logic        hv = 0, he = 0;
  logic [31:0] hd = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (enabled cycle %0d)", name, act, exp, ecyc);
    end
  endtask

  // One clock cycle of stimulus; the model applies the write first, so a same-address read sees it
  task automatic cyc(input logic ce, input logic re, input logic [7:0] ra,
                     input logic we, input logic [7:0] wa, input logic [31:0] wd, input logic [3:0] be);
    exp_t e;
    clk_enable = ce; r_enable = re; r_address = ra;
    w_enable = we; w_address = wa; w_data = wd; w_byte_enable = be;
    @(posedge clk);
    if (ce) begin
      ecyc++;
      if (we && int'(wa) < DEPTH)
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[wa][8*b +: 8] = wd[8*b +: 8];
      if (re) begin
        e.due  = ecyc + RL - 1;
        e.err  = int'(ra) >= DEPTH;
        e.data = e.err ? 32'h0 : ref_mem[ra];
        q.push_back(e);
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic async_reset();
    #2 rst = 1;
    #1;
    chk("reset_valid", 32'(o_valid), 0);
    chk("reset_error", 32'(o_error), 0);
    chk("reset_data", o_data, 0);
    q.delete();
    hv = 0; hd = 0; he = 0;
    @(posedge clk);
    #1 rst = 0;
  endtask

  // Monitor: on each new enabled cycle compare against the queue head; while frozen, outputs must hold
  initial begin
    forever begin
      @(negedge clk);
      if (rst) continue;
      if (ecyc != last) begin
        last = ecyc;
        while (q.size() != 0 && q[0].due < ecyc) begin
          chk("missing_response", 32'(o_valid), 1);
          void'(q.pop_front());
        end
        if (q.size() != 0 && q[0].due == ecyc) begin
          chk("resp_valid", 32'(o_valid), 1);
          chk("resp_data", o_data, q[0].data);
          chk("resp_error", 32'(o_error), 32'(q[0].err));
          void'(q.pop_front());
        end else begin
          chk("bubble_valid", 32'(o_valid), 0);
          chk("bubble_error", 32'(o_error), 0);
        end
        hv = o_valid; hd = o_data; he = o_error;
      end else begin
        chk("hold_valid", 32'(o_valid), 32'(hv));
        chk("hold_data", o_data, hd);
        chk("hold_error", 32'(o_error), 32'(he));
      end
    end
  end

  initial begin
    @(posedge clk);
    #1;
    chk("init_valid", 32'(o_valid), 0);
    chk("init_error", 32'(o_error), 0);
    chk("init_data", o_data, 0);
    rst = 0;
    for (int a = 0; a < DEPTH; a++) cyc(1, 0, 0, 1, 8'(a), $urandom, 4'hf);
    cyc(1, 0, 0, 1, 0, 10, 4'hf);
    cyc(1, 0, 0, 1, 1, 20, 4'hf);
    cyc(1, 0, 0, 1, 2, 30, 4'hf);
    cyc(1, 0, 0, 1, 4, 32'h55, 4'hf);
    cyc(1, 0, 0, 1, 5, 32'hAABBCCDD, 4'hf);
    cyc(1, 0, 0, 1, 5, 32'h11223344, 4'b0101);
    cyc(1, 0, 0, 1, 5, 32'hFFFFFFFF, 4'b0000);
    cyc(1, 1, 5, 0, 0, 0, 0);
    cyc(1, 1, 9, 1, 9, 32'h12345678, 4'hf);
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 0);
    cyc(1, 1, 2, 0, 0, 0, 0);
    cyc(1, 1, 4, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 4, 32'h99, 4'hf);
    idle(1);
    cyc(1, 1, 4, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 210, 32'hDEAD, 4'hf);
    cyc(1, 1, 210, 0, 0, 0, 0);
    cyc(1, 1, 199, 0, 0, 0, 0);
    cyc(1, 1, 255, 1, 3, 32'hCAFE0000, 4'b1100);
    idle(RL + 1);
    cyc(1, 1, 3, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 8'(i), 1, 3, 32'hBAD0BAD0, 4'hf);
    idle(RL + 1);
    cyc(1, 1, 7, 0, 0, 0, 0);
    idle(1);
    async_reset();
    idle(RL + 2);
    for (int i = 0; i < 1500; i++) begin
      logic [7:0] ra;
      ra = 8'($urandom_range(0, 255));
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1, ra,
          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1 ? ra : 8'($urandom_range(0, 255)),
          $urandom, 4'($urandom_range(0, 15)));
    end
    idle(RL + 2);
    chk("queue_drained", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
